// File: rtl/switch_conditioner_if.sv
// Bus-side bundle for switch_conditioner: raw pins, interrupt masks, ack strobe
// and the conditioned outputs. fall_mask exists only when
// SWITCH_CONDITIONER_FALL_EDGE_EN is defined.
interface switch_conditioner_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_clean;
    logic [WIDTH-1:0] rise_mask;
    logic             ack;
    logic [WIDTH-1:0] ack_mask;
    logic [WIDTH-1:0] pending;
    logic             irq;
`ifdef SWITCH_CONDITIONER_FALL_EDGE_EN
    logic [WIDTH-1:0] fall_mask;

    modport master (
        output sw_raw, rise_mask, ack, ack_mask, fall_mask,
        input  sw_clean, pending, irq
    );

    modport slave (
        input  sw_raw, rise_mask, ack, ack_mask, fall_mask,
        output sw_clean, pending, irq
    );
`else
    modport master (
        output sw_raw, rise_mask, ack, ack_mask,
        input  sw_clean, pending, irq
    );

    modport slave (
        input  sw_raw, rise_mask, ack, ack_mask,
        output sw_clean, pending, irq
    );
`endif
endinterface

// File: rtl/switch_conditioner.sv
// Switch conditioner: two-flop synchronizer, per-bit debounce counter and sticky
// edge-triggered interrupt flags with OR-reduced irq.
// Define SWITCH_CONDITIONER_FALL_EDGE_EN to add fall_mask and falling-edge capture.
module switch_conditioner #(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input logic              clk,
    input logic              reset,
    switch_conditioner_if.slave bus_io
);
    localparam int unsigned    CntW    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]           s1_q;
    logic [WIDTH-1:0]           s2_q;
    logic [WIDTH-1:0]           clean_q;
    logic [WIDTH-1:0]           clean_d;
    logic [WIDTH-1:0][CntW-1:0] cnt_q;
    logic [WIDTH-1:0][CntW-1:0] cnt_d;
    logic [WIDTH-1:0]           pend_q;
    logic [WIDTH-1:0]           pend_d;
    logic [WIDTH-1:0]           set_vec;
    logic [WIDTH-1:0]           clr_vec;

    // Two-flop synchronizer on the raw pins, nothing between the stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= bus_io.sw_raw;
            s2_q <= s1_q;
        end
    end

    // Debounce: count consecutive disagreeing cycles, accept on the last one.
    always_comb begin
        clean_d = clean_q;
        cnt_d   = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (s2_q[i] != clean_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    clean_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    // Interrupt flags: edges of the debounced level set, ack clears, set wins.
    always_comb begin
        set_vec = clean_d & ~clean_q & bus_io.rise_mask;
`ifdef SWITCH_CONDITIONER_FALL_EDGE_EN
        set_vec = set_vec | (~clean_d & clean_q & bus_io.fall_mask);
`endif
        clr_vec = bus_io.ack ? bus_io.ack_mask : '0;
        pend_d  = (pend_q & ~clr_vec) | set_vec;
    end

    // Debounced level, counters and pending flags; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            clean_q <= '0;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    assign bus_io.sw_clean = clean_q;
    assign bus_io.pending  = pend_q;
    assign bus_io.irq      = |pend_q;
endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: directed scenarios followed by randomized pin
// activity, all compared against a history-window reference model.
module tb_switch_conditioner;
    localparam int unsigned W = 16;
    localparam int unsigned D = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    switch_conditioner_if #(.WIDTH(W)) bus ();

    switch_conditioner #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus_io(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    // Reference model: synchronizer as two delayed copies, debounced level flips
    // when the last D synchronized samples all disagree with it.
    logic [W-1:0] m_s1, m_s2, m_clean, m_pend;
    logic [W-1:0] hist[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %h expected %h", tag, edge_cnt, got, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic [W-1:0] raw, input logic [W-1:0] rmask,
                              input logic a, input logic [W-1:0] amask,
                              input logic [W-1:0] fmask);
        logic [W-1:0] flip, nclean, setv, clrv;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_clean = '0; m_pend = '0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > D) void'(hist.pop_front());
            flip = (hist.size() == D) ? '1 : '0;
            foreach (hist[k]) flip &= hist[k] ^ m_clean;
            nclean = m_clean ^ flip;
            setv = nclean & ~m_clean & rmask;
`ifdef SWITCH_CONDITIONER_FALL_EDGE_EN
            setv |= m_clean & ~nclean & fmask;
`else
            setv |= fmask & '0;
`endif
            clrv = a ? amask : '0;
            m_pend  = (m_pend & ~clrv) | setv;
            m_clean = nclean;
            m_s2 = m_s1;
            m_s1 = raw;
        end
    endtask

    task automatic step(input logic rst, input logic [W-1:0] raw, input logic [W-1:0] rmask,
                        input logic a, input logic [W-1:0] amask, input logic [W-1:0] fmask);
        reset         = rst;
        bus.sw_raw    = raw;
        bus.rise_mask = rmask;
        bus.ack       = a;
        bus.ack_mask  = amask;
`ifdef SWITCH_CONDITIONER_FALL_EDGE_EN
        bus.fall_mask = fmask;
`endif
        model_edge(rst, raw, rmask, a, amask, fmask);
        @(posedge clk);
        #1;
        edge_cnt++;
        check_eq("sw_clean", 32'(bus.sw_clean), 32'(m_clean));
        check_eq("pending", 32'(bus.pending), 32'(m_pend));
        check_eq("irq", 32'(bus.irq), 32'(|m_pend));
    endtask

    initial begin
        logic [W-1:0] raw, rm, am, fm;
        int rate;
        m_s1 = '0; m_s2 = '0; m_clean = '0; m_pend = '0;

        // Latency from reset, rising-edge capture and ack clear on bit 0.
        step(1'b1, '0, '0, 1'b0, '0, '0);
        edge_cnt = 0;
        for (int e = 1; e <= 15; e++) begin
            step(1'b0, (e >= 10) ? 16'h0001 : 16'h0000, 16'h0001, 1'b0, '0, '0);
            if (e == 14) check_eq("req030_e14", 32'(bus.sw_clean[0]), 32'd0);
            if (e == 15) begin
                check_eq("req030_e15", 32'(bus.sw_clean[0]), 32'd1);
                check_eq("req032_pend", 32'(bus.pending), 32'h0001);
                check_eq("req032_irq", 32'(bus.irq), 32'd1);
            end
        end
        step(1'b0, 16'h0001, 16'h0001, 1'b1, 16'h0001, '0);
        check_eq("req032_ack_pend", 32'(bus.pending), 32'h0000);
        check_eq("req032_ack_irq", 32'(bus.irq), 32'd0);

        // Short pulse on bit 3 must be rejected.
        for (int k = 0; k < 13; k++) begin
            step(1'b0, (k < 3) ? 16'h0009 : 16'h0001, 16'hFFFF, 1'b0, '0, '0);
            check_eq("req031_clean3", 32'(bus.sw_clean[3]), 32'd0);
            check_eq("req031_pend", 32'(bus.pending), 32'h0000);
            check_eq("req031_irq", 32'(bus.irq), 32'd0);
        end

        // Set beats a simultaneous ack on bit 2.
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 16'h0005, 16'h0004, (k == 5), 16'h0004, '0);
        end
        check_eq("req033_clean2", 32'(bus.sw_clean[2]), 32'd1);
        check_eq("req033_pend2", 32'(bus.pending[2]), 32'd1);

        // Reset in the middle of a debounce count.
        step(1'b1, 16'hFFFF, '0, 1'b0, '0, '0);
        for (int k = 0; k < 4; k++) step(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, '0, '0);
        step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, '0);
        check_eq("req034_clean", 32'(bus.sw_clean), 32'h0);
        check_eq("req034_pend", 32'(bus.pending), 32'h0);
        check_eq("req034_irq", 32'(bus.irq), 32'd0);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 16'hFFFF, '0, 1'b0, '0, '0);
            if (k == 4) check_eq("req034_early", 32'(bus.sw_clean), 32'h0);
            if (k == 5) check_eq("req034_done", 32'(bus.sw_clean), 32'hFFFF);
        end

`ifdef SWITCH_CONDITIONER_FALL_EDGE_EN
        // Falling-edge capture on bit 15.
        for (int k = 0; k < 6; k++) step(1'b0, 16'h7FFF, '0, 1'b0, '0, 16'h8000);
        check_eq("req035_pend", 32'(bus.pending), 32'h8000);
        check_eq("req035_irq", 32'(bus.irq), 32'd1);
`endif

        // Randomized pins: alternating bouncy and calm segments.
        raw  = bus.sw_raw;
        rate = 4;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) rate = (($urandom_range(0, 1) == 0) ? 3 : 40);
            for (int b = 0; b < int'(W); b++) begin
                if ($urandom_range(0, rate) == 0) raw[b] = ~raw[b];
            end
            rm = W'($urandom);
            am = W'($urandom);
            fm = W'($urandom);
            step(($urandom_range(0, 399) == 0), raw, rm, ($urandom_range(0, 3) == 0), am, fm);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/switch_conditioner.md
SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 SHALL have parameter WIDTH, default 16, number of switch inputs conditioned.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable cycles required to accept a new level; legal range 1..255.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sw_raw  input  WIDTH  asynchronous switch levels from the board pins.
REQ-006 SHALL have port sw_clean  output  WIDTH  registered, synchronized, debounced levels for the peripheral bus.
REQ-007 SHALL have port rise_mask  input  WIDTH  per-bit enable for rising-edge interrupt capture.
REQ-008 SHALL have port ack  input  1  pending-clear strobe from the peripheral bus.
REQ-009 SHALL have port ack_mask  input  WIDTH  pending bits cleared when ack=1.
REQ-010 SHALL have port pending  output  WIDTH  registered sticky per-bit interrupt flags.
REQ-011 SHALL have port irq  output  1  OR-reduction of pending; drives the core interrupt line.

Function
REQ-012 SHALL pass each sw_raw bit through a two-flop synchronizer (s1, s2) with no other logic between the flops.
REQ-013 SHALL keep one counter per bit, width ceil(log2(DEBOUNCE_CYCLES))+1, no wrap-around.
REQ-014 SHALL, each edge where s2[i]==sw_clean[i], clear counter i.
REQ-015 SHALL, each edge where s2[i]!=sw_clean[i] and counter i < DEBOUNCE_CYCLES-1, increment counter i.
REQ-016 SHALL, each edge where s2[i]!=sw_clean[i] and counter i == DEBOUNCE_CYCLES-1, load sw_clean[i]<=s2[i] and clear counter i.
REQ-017 SHALL yield latency: sw_raw stable from before edge N -> sw_clean updated after edge N+1+DEBOUNCE_CYCLES.
REQ-018 SHALL reject any s2 pulse shorter than DEBOUNCE_CYCLES cycles (sw_clean unchanged, counter back to 0).
REQ-019 SHALL, on the same edge sw_clean[i] goes 0->1 and rise_mask[i]=1, set pending[i].
REQ-020 SHALL, on an edge with ack=1, clear pending[i] for every bit with ack_mask[i]=1.
REQ-021 SHALL give set priority over clear when both occur for the same bit on the same edge.
REQ-022 SHALL leave pending bits unaffected by rise_mask changes after they are set.
REQ-023 SHALL drive irq combinationally as |pending, with no added latency.
REQ-024 SHALL process all bits independently; simultaneous events on several bits all take effect.

Reset
REQ-025 SHALL, on an edge with reset=1, clear s1, s2, sw_clean, all counters and pending; irq therefore 0.
REQ-026 SHALL let reset override every other input, including ack and in-progress debounce counts.
REQ-027 SHALL, after reset deasserts with sw_raw[i]=1, treat the bit as a normal 0->1 transition (sw_clean rises per REQ-017, may set pending).

Configuration
REQ-028 SHALL compile in, when macro SWITCH_CONDITIONER_FALL_EDGE_EN is defined, an extra input fall_mask (WIDTH) that sets pending[i] when sw_clean[i] goes 1->0 with fall_mask[i]=1, same priority rules as REQ-019..021.
REQ-029 SHALL, without SWITCH_CONDITIONER_FALL_EDGE_EN, have no fall_mask port and ignore falling edges for pending.

Verification
REQ-030 SHALL check: DEBOUNCE_CYCLES=4, reset, sw_raw[0] 0->1 before edge 10, held -> sw_clean[0]=1 after edge 15, not after 14.
REQ-031 SHALL check: sw_raw[3] high for 3 cycles then low -> sw_clean[3] stays 0, pending stays 0, irq stays 0.
REQ-032 SHALL check: rise_mask=16'h0001, sw_raw[0] rises -> pending=16'h0001, irq=1 on the same edge sw_clean[0] rises; ack=1, ack_mask=16'h0001 one cycle -> pending=0, irq=0 next edge.
REQ-033 SHALL check: sw_clean[2] rises with rise_mask[2]=1 on the same edge as ack=1, ack_mask=16'h0004 -> pending[2]=1.
REQ-034 SHALL check: reset=1 asserted mid-count (counter at 2) with sw_raw=16'hFFFF -> all outputs 0 next edge; after release sw_clean=16'hFFFF after 1+4 further edges.
REQ-035 SHALL check, with SWITCH_CONDITIONER_FALL_EDGE_EN defined, fall_mask=16'h8000, sw_raw[15] 1->0 after settling -> pending=16'h8000, irq=1.
